// File: rtl/tcp_pkg.sv
// Shared TCP offload definitions.
// Provides the flow-id / payload pointer widths used across the RX path and
// the request/response records exchanged between the app read engine and
// rx_app_ptr_ctrl.
package tcp_pkg;

  localparam int FLOWID_W         = 4;
  localparam int RX_PAYLOAD_PTR_W = 16;
  // Payload pointers carry one extra wrap bit above the buffer index.
  localparam int RX_APP_PTR_W     = RX_PAYLOAD_PTR_W + 1;

  typedef struct packed {
    logic [FLOWID_W-1:0]     flowid;
    logic [RX_APP_PTR_W-1:0] len;
  } rx_app_ptr_req_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0]     flowid;
    logic [RX_APP_PTR_W-1:0] head;
    logic [RX_APP_PTR_W-1:0] avail;
    logic [RX_APP_PTR_W-1:0] grant;
    logic                    err;
  } rx_app_ptr_resp_struct;

endpackage

// File: rtl/rx_app_ptr_ctrl_grant_calc.sv
// rx_ptr_grant_calc: combinational grant arithmetic for one flow.
//   head_i, commit_i : current head / commit pointers (MSB is the wrap bit)
//   len_i            : bytes the app wants to consume (0 = query)
//   avail_o          : commit - head, mod 2^PTR_W
//   grant_o          : bytes granted
//   new_head_o       : head + grant, mod 2^PTR_W (carry dropped, MSB toggles)
//   err_o            : overrun rejected (only possible with CLAMP_EN = 0)
module rx_ptr_grant_calc #(
  parameter bit CLAMP_EN = 1'b1,
  parameter int PTR_W    = 17
) (
  input  logic [PTR_W-1:0] head_i,
  input  logic [PTR_W-1:0] commit_i,
  input  logic [PTR_W-1:0] len_i,
  output logic [PTR_W-1:0] avail_o,
  output logic [PTR_W-1:0] grant_o,
  output logic [PTR_W-1:0] new_head_o,
  output logic             err_o
);

  always_comb begin
    avail_o = commit_i - head_i;
    err_o   = 1'b0;
    grant_o = '0;
    if (CLAMP_EN) begin
      grant_o = (len_i < avail_o) ? len_i : avail_o;
    end else begin
      err_o   = (len_i > avail_o);
      grant_o = err_o ? '0 : len_i;
    end
    new_head_o = head_i + grant_o;
  end

endmodule

// File: rtl/rx_app_ptr_ctrl.sv
// rx_app_ptr_ctrl: per-flow RX head pointer controller for the app read path.
// Accepts one "consume up to len bytes of flow F" request at a time, reads
// the flow's head and commit pointers (rd1 ports), grants min(len, avail),
// writes the advanced head back and returns head/avail/grant/err.
//   app_req_*     : request in (val/rdy), flowid + len
//   app_resp_*    : response out (val/rdy), flowid/head/avail/grant/err
//   head_rd_*     : head pointer memory read request/response
//   commit_rd_*   : commit pointer memory read request/response
//   head_wr_req_* : head pointer memory write
module rx_app_ptr_ctrl
  import tcp_pkg::*;
#(
  parameter bit CLAMP_EN = 1'b1,
  parameter int PTR_W    = RX_PAYLOAD_PTR_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                app_req_val,
  input  logic [FLOWID_W-1:0] app_req_flowid,
  input  logic [PTR_W-1:0]    app_req_len,
  output logic                app_req_rdy,
  output logic                app_resp_val,
  output logic [FLOWID_W-1:0] app_resp_flowid,
  output logic [PTR_W-1:0]    app_resp_head,
  output logic [PTR_W-1:0]    app_resp_avail,
  output logic [PTR_W-1:0]    app_resp_grant,
  output logic                app_resp_err,
  input  logic                app_resp_rdy,
  output logic                head_rd_req_val,
  output logic [FLOWID_W-1:0] head_rd_req_addr,
  input  logic                head_rd_req_rdy,
  input  logic                head_rd_resp_val,
  input  logic [PTR_W-1:0]    head_rd_resp_data,
  output logic                head_rd_resp_rdy,
  output logic                commit_rd_req_val,
  output logic [FLOWID_W-1:0] commit_rd_req_addr,
  input  logic                commit_rd_req_rdy,
  input  logic                commit_rd_resp_val,
  input  logic [PTR_W-1:0]    commit_rd_resp_data,
  output logic                commit_rd_resp_rdy,
  output logic                head_wr_req_val,
  output logic [FLOWID_W-1:0] head_wr_req_addr,
  output logic [PTR_W-1:0]    head_wr_req_data,
  input  logic                head_wr_req_rdy
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR, RESP} state_e;

  state_e              state_q, state_d;
  logic [FLOWID_W-1:0] flowid_q, flowid_d;
  logic [PTR_W-1:0]    len_q, len_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    cmt_q, cmt_d;
  logic [PTR_W-1:0]    avail_q, avail_d;
  logic [PTR_W-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]    new_head_q, new_head_d;
  logic                err_q, err_d;
  // Per-port progress: request accepted (iss) and response captured (cap).
  logic                head_iss_q, head_iss_d, cmt_iss_q, cmt_iss_d;
  logic                head_cap_q, head_cap_d, cmt_cap_q, cmt_cap_d;

  logic [PTR_W-1:0]    head_cur, cmt_cur;
  logic [PTR_W-1:0]    calc_avail, calc_grant, calc_new_head;
  logic                calc_err;

  // Use a response straight off the port in the cycle it arrives so the
  // result can be computed in the same RD_RESP cycle as the last capture.
  assign head_cur = head_cap_q ? head_q : head_rd_resp_data;
  assign cmt_cur  = cmt_cap_q  ? cmt_q  : commit_rd_resp_data;

  rx_ptr_grant_calc #(
    .CLAMP_EN (CLAMP_EN),
    .PTR_W    (PTR_W)
  ) u_calc (
    .head_i     (head_cur),
    .commit_i   (cmt_cur),
    .len_i      (len_q),
    .avail_o    (calc_avail),
    .grant_o    (calc_grant),
    .new_head_o (calc_new_head),
    .err_o      (calc_err)
  );

  always_comb begin
    state_d            = state_q;
    flowid_d           = flowid_q;
    len_d              = len_q;
    head_d             = head_q;
    cmt_d              = cmt_q;
    avail_d            = avail_q;
    grant_d            = grant_q;
    new_head_d         = new_head_q;
    err_d              = err_q;
    head_iss_d         = head_iss_q;
    cmt_iss_d          = cmt_iss_q;
    head_cap_d         = head_cap_q;
    cmt_cap_d          = cmt_cap_q;
    app_req_rdy        = 1'b0;
    app_resp_val       = 1'b0;
    head_rd_req_val    = 1'b0;
    commit_rd_req_val  = 1'b0;
    head_rd_resp_rdy   = 1'b0;
    commit_rd_resp_rdy = 1'b0;
    head_wr_req_val    = 1'b0;

    case (state_q)
      IDLE: begin
        app_req_rdy = 1'b1;
        if (app_req_val) begin
          flowid_d   = app_req_flowid;
          len_d      = app_req_len;
          head_iss_d = 1'b0;
          cmt_iss_d  = 1'b0;
          head_cap_d = 1'b0;
          cmt_cap_d  = 1'b0;
          state_d    = RD_REQ;
        end
      end
      RD_REQ: begin
        // Each port drops its request once accepted, so a slow port never
        // causes the other to be re-issued.
        head_rd_req_val   = !head_iss_q;
        commit_rd_req_val = !cmt_iss_q;
        if (head_rd_req_val && head_rd_req_rdy)     head_iss_d = 1'b1;
        if (commit_rd_req_val && commit_rd_req_rdy) cmt_iss_d  = 1'b1;
        if (head_iss_d && cmt_iss_d)                state_d    = RD_RESP;
      end
      RD_RESP: begin
        head_rd_resp_rdy   = 1'b1;
        commit_rd_resp_rdy = 1'b1;
        if (head_rd_resp_val && !head_cap_q) begin
          head_cap_d = 1'b1;
          head_d     = head_rd_resp_data;
        end
        if (commit_rd_resp_val && !cmt_cap_q) begin
          cmt_cap_d = 1'b1;
          cmt_d     = commit_rd_resp_data;
        end
        if (head_cap_d && cmt_cap_d) begin
          head_d     = head_cur;
          avail_d    = calc_avail;
          grant_d    = calc_grant;
          new_head_d = calc_new_head;
          err_d      = calc_err;
          state_d    = (calc_grant != '0 && !calc_err) ? WR : RESP;
        end
      end
      WR: begin
        head_wr_req_val = 1'b1;
        if (head_wr_req_rdy) state_d = RESP;
      end
      RESP: begin
        app_resp_val = 1'b1;
        if (app_resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshakes are silenced during the reset cycle itself so an in-flight
    // head write can never complete once reset is seen.
    if (rst) begin
      app_req_rdy        = 1'b0;
      app_resp_val       = 1'b0;
      head_rd_req_val    = 1'b0;
      commit_rd_req_val  = 1'b0;
      head_rd_resp_rdy   = 1'b0;
      commit_rd_resp_rdy = 1'b0;
      head_wr_req_val    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flowid_q   <= '0;
      len_q      <= '0;
      head_q     <= '0;
      cmt_q      <= '0;
      avail_q    <= '0;
      grant_q    <= '0;
      new_head_q <= '0;
      err_q      <= 1'b0;
      head_iss_q <= 1'b0;
      cmt_iss_q  <= 1'b0;
      head_cap_q <= 1'b0;
      cmt_cap_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      flowid_q   <= flowid_d;
      len_q      <= len_d;
      head_q     <= head_d;
      cmt_q      <= cmt_d;
      avail_q    <= avail_d;
      grant_q    <= grant_d;
      new_head_q <= new_head_d;
      err_q      <= err_d;
      head_iss_q <= head_iss_d;
      cmt_iss_q  <= cmt_iss_d;
      head_cap_q <= head_cap_d;
      cmt_cap_q  <= cmt_cap_d;
    end
  end

  assign app_resp_flowid    = flowid_q;
  assign app_resp_head      = head_q;
  assign app_resp_avail     = avail_q;
  assign app_resp_grant     = grant_q;
  assign app_resp_err       = err_q;
  assign head_rd_req_addr   = flowid_q;
  assign commit_rd_req_addr = flowid_q;
  assign head_wr_req_addr   = flowid_q;
  assign head_wr_req_data   = new_head_q;

`ifndef SYNTHESIS
  // A read response is only legal while its request is outstanding.
  a_head_resp_pending : assert property (@(posedge clk) disable iff (rst)
    head_rd_resp_val |-> (head_iss_q && !head_cap_q));
  a_cmt_resp_pending : assert property (@(posedge clk) disable iff (rst)
    commit_rd_resp_val |-> (cmt_iss_q && !cmt_cap_q));
`endif

endmodule
